// File: rtl/llsc_mem_ctrl.sv
// llsc_mem_ctrl: memory-stage controller for word loads/stores and the LL/SC pair.
// Sequences each access through a registered bus request/acknowledge handshake,
// stalls the pipeline until the access completes and drives the LLbit write port.
// Optional feature: define LLSC_TIMEOUT_EN to add a bus watchdog that aborts
// a BUS wait after TIMEOUT_CYCLES cycles without acknowledge.

module llsc_mem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [2:0]  op_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] reg2_i,
  input  logic        llbit_i,
  input  logic        wb_llbit_we_i,
  input  logic        wb_llbit_value_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        llbit_we_o,
  output logic        llbit_value_o,
  output logic        stallreq_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_sel_o,
  output logic [31:0] mem_wdata_o,
  output logic        exc_misalign_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [2:0] OP_LW = 3'd1;
  localparam logic [2:0] OP_SW = 3'd2;
  localparam logic [2:0] OP_LL = 3'd3;
  localparam logic [2:0] OP_SC = 3'd4;

  state_e      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_sel_q, mem_sel_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  // Operation captured at issue; op_i is not trusted once the access is in flight.
  logic [2:0]  op_q, op_d;

`ifdef LLSC_TIMEOUT_EN
  localparam int unsigned      CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d;

  assign bus_err_o = bus_err_q;
`else
  assign bus_err_o = 1'b0;
`endif

  // Operation decode and LLbit forwarding from WB.
  logic is_load, is_store, is_mem, is_sc, misalign, llbit_eff, sc_fail;

  assign is_load   = (op_i == OP_LW) || (op_i == OP_LL);
  assign is_store  = (op_i == OP_SW) || (op_i == OP_SC);
  assign is_mem    = is_load || is_store;
  assign is_sc     = (op_i == OP_SC);
  assign misalign  = is_mem && (addr_i[1:0] != 2'b00);
  assign llbit_eff = wb_llbit_we_i ? wb_llbit_value_i : llbit_i;
  assign sc_fail   = is_sc && !llbit_eff;

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_sel_o   = mem_sel_q;
  assign mem_wdata_o = mem_wdata_q;

  // Next-state, bus register updates and combinational pipeline outputs.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    state_d        = state_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_sel_d      = mem_sel_q;
    mem_wdata_d    = mem_wdata_q;
    rdata_d        = rdata_q;
    op_d           = op_q;
    wd_o           = wd_i;
    wreg_o         = 1'b0;
    wdata_o        = wdata_i;
    llbit_we_o     = 1'b0;
    llbit_value_o  = 1'b0;
    stallreq_o     = 1'b0;
    exc_misalign_o = 1'b0;
`ifdef LLSC_TIMEOUT_EN
    cnt_d          = cnt_q;
    bus_err_d      = 1'b0;
`endif

    if (rst) begin
      // Registers are cleared by the flop reset; only the outputs need forcing.
      wd_o    = '0;
      wdata_o = '0;
    end else if (flush) begin
      // Abort whatever is in flight; a late ack then finds the FSM in IDLE.
      state_d   = ST_IDLE;
      mem_req_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
`ifdef LLSC_TIMEOUT_EN
          if (bus_err_q) begin
            // Watchdog abort cycle: the timed-out op is dropped, not retried.
            wreg_o = 1'b0;
          end else
`endif
          if (!is_mem) begin
            wreg_o = wreg_i;
          end else if (misalign) begin
            exc_misalign_o = 1'b1;
          end else if (sc_fail) begin
            // Failed SC completes at once with result 0 and no bus traffic.
            wreg_o  = wreg_i;
            wdata_o = '0;
          end else begin
            stallreq_o  = 1'b1;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store;
            mem_addr_d  = addr_i;
            mem_sel_d   = 4'b1111;
            mem_wdata_d = reg2_i;
            op_d        = op_i;
            state_d     = ST_BUS;
`ifdef LLSC_TIMEOUT_EN
            cnt_d       = '0;
`endif
          end
        end

        ST_BUS: begin
          stallreq_o = 1'b1;
          if (mem_ack_i) begin
            mem_req_d = 1'b0;
            if ((op_q == OP_LW) || (op_q == OP_LL)) begin
              rdata_d = mem_rdata_i;
            end
            state_d = ST_DONE;
          end
`ifdef LLSC_TIMEOUT_EN
          else if (cnt_q == CNT_LAST) begin
            mem_req_d = 1'b0;
            bus_err_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`endif
        end

        ST_DONE: begin
          wreg_o  = wreg_i;
          state_d = ST_IDLE;
          case (op_q)
            OP_LW: begin
              wdata_o = rdata_q;
            end
            OP_LL: begin
              wdata_o       = rdata_q;
              llbit_we_o    = 1'b1;
              llbit_value_o = 1'b1;
            end
            OP_SC: begin
              wdata_o       = 32'd1;
              llbit_we_o    = 1'b1;
              llbit_value_o = 1'b0;
            end
            default: begin
              wdata_o = wdata_i;
            end
          endcase
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and bus-side registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_sel_q   <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      op_q        <= '0;
`ifdef LLSC_TIMEOUT_EN
      cnt_q       <= '0;
      bus_err_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_sel_q   <= mem_sel_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      op_q        <= op_d;
`ifdef LLSC_TIMEOUT_EN
      cnt_q       <= cnt_d;
      bus_err_q   <= bus_err_d;
`endif
    end
  end

endmodule

// File: doc/llsc_mem_ctrl.md
# llsc_mem_ctrl

Memory-stage controller for word loads/stores and the LL/SC pair. It sits between the EX/MEM pipeline register and the data bus, and drives the write port of the LLbit register. It sequences each memory access through a bus request/acknowledge handshake, stalls the pipeline until completion, and decides SC success from the forwarded LLbit value.

## Interface
- TIMEOUT_CYCLES, 16: bus watchdog limit in cycles; used only with `LLSC_TIMEOUT_EN`.
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  exception flush; aborts the in-flight access
- op_i  in  3  0=pass, 1=LW, 2=SW, 3=LL, 4=SC; 5-7 are treated as pass
- wd_i / wreg_i / wdata_i  in  5/1/32  destination register, write enable, ALU result
- addr_i / reg2_i  in  32/32  effective address, store data
- llbit_i  in  1  current LLbit register value
- wb_llbit_we_i / wb_llbit_value_i  in  1/1  LLbit write in flight in WB (forwarding)
- mem_rdata_i / mem_ack_i  in  32/1  bus read data, acknowledge
- wd_o / wreg_o / wdata_o  out  5/1/32  result to MEM/WB
- llbit_we_o / llbit_value_o  out  1/1  LLbit register write port
- stallreq_o  out  1  pipeline stall request
- mem_req_o / mem_we_o / mem_addr_o / mem_sel_o / mem_wdata_o  out  1/1/32/4/32  bus request, registered
- exc_misalign_o  out  1  address error, addr_i[1:0]≠0 on a memory op
- bus_err_o  out  1  watchdog abort, pulses for one cycle

## Operation
- Effective LLbit: wb_llbit_value_i if wb_llbit_we_i, else llbit_i.
- FSM states: IDLE, BUS, DONE. Reset state is IDLE.
- IDLE, pass op: wd_o, wreg_o and wdata_o follow the inputs combinationally. llbit_we_o=0, stallreq_o=0.
- IDLE, memory op with addr_i[1:0]≠0: exc_misalign_o=1, wreg_o=0, no bus access, no LLbit write, no stall.
- IDLE, SC with effective LLbit=0: no bus access. wreg_o=wreg_i, wdata_o=0, llbit_we_o=0, no stall.
- IDLE, any other memory op:
  - stallreq_o=1.
  - Register mem_req_o=1, mem_addr_o=addr_i, mem_sel_o=4'b1111.
  - mem_we_o=1 for SW/SC, 0 for LW/LL; mem_wdata_o=reg2_i.
  - Next state is BUS.
- BUS: stallreq_o=1. On mem_ack_i, latch mem_rdata_i (loads), drop mem_req_o, go to DONE.
- DONE, one cycle: stallreq_o=0, wreg_o=wreg_i, wd_o=wd_i.
  - wdata_o = latched data for LW/LL, 1 for SC, wdata_i for SW.
  - LL: llbit_we_o=1, llbit_value_o=1.
  - SC: llbit_we_o=1, llbit_value_o=0.
  - op_i is ignored in DONE. Next state is IDLE.
- flush in any state: next state IDLE, mem_req_o=0 next cycle, no LLbit write, wreg_o=0 and stallreq_o=0 in the flush cycle. An ack arriving after a flush is ignored.
- Reset values: mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_sel_o=0, mem_wdata_o=0, latched data=0, bus_err_o=0. All combinational outputs are 0 while rst=1.

## Timing
- Memory op seen in IDLE at cycle T: mem_req_o=1 from T+1.
- Ack in cycle A≥T+1: DONE at A+1, stall asserted T..A.
- Minimum occupancy is 3 cycles, with stall at T and T+1.
- mem_ack_i is sampled only in BUS. An ack while in IDLE or DONE is ignored.
- LLbit write issues in DONE and lands in the register at the next edge. The WB forwarding path covers a back-to-back SC.
- flush takes priority over ack in the same cycle. rst takes priority over flush.

## Configuration
- `LLSC_TIMEOUT_EN` defined:
  - A counter clears on entry to BUS and increments each BUS cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES, mem_req_o drops and the FSM goes to IDLE.
  - bus_err_o=1 for that one cycle, wreg_o=0, no LLbit write.
- Undefined: no counter; BUS waits indefinitely; bus_err_o is tied to 0.

## Test plan
- LW at 0x100, ack 2 cycles after request with rdata 0xDEADBEEF -> stallreq_o high 3 cycles, then wdata_o=0xDEADBEEF with wreg_o=1 for one cycle.
- LL at 0x200 followed by SC at 0x200 with LLbit forwarded from WB, ack immediate -> SC issues a bus write of reg2_i, wdata_o=1, llbit_we_o=1 with llbit_value_o=0.
- SC with llbit_i=0 and no WB write -> no mem_req_o, wdata_o=0, no stall.
- SW at 0x102 -> exc_misalign_o=1, mem_req_o stays 0, wreg_o=0.
- LW with flush asserted the cycle after the request, ack one cycle later -> mem_req_o low the cycle after flush, ack ignored, no register write.
- With `LLSC_TIMEOUT_EN` and TIMEOUT_CYCLES=4, no ack -> bus_err_o pulses after 4 BUS cycles, FSM returns to IDLE, stallreq_o drops.
